// File: rtl/truth_table_seq_pkg.sv
// Shared types and helpers for the runtime-programmable truth-table gate:
// loader state encoding, table-width derivation and the table bit-order constant.
package truth_table_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } loader_state_e;

    // Index 0 selects the table MSB (Wolfram code ordering)
    localparam bit WOLFRAM_MSB_FIRST = 1'b1;

    function automatic int tt_width(input int n);
        return 32'sd1 << n;
    endfunction

endpackage

// File: rtl/truth_table_seq_loader.sv
// Serial table loader: collects TT_W bits MSB first into a shadow register and
// raises a one-cycle commit (with cfg_done) once the last bit has been accepted.
module truth_table_loader
    import truth_table_pkg::*;
#(
    parameter int TT_W = 8
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_ready,
    output logic            cfg_done,
    output logic            commit,
    output logic [TT_W-1:0] shadow
);

    localparam int CNT_W = $clog2(TT_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TT_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    loader_state_e    state_r;
    logic [CNT_W-1:0] count_r;
    logic [TT_W-1:0]  shadow_r;
    logic             ready_r;
    logic             done_r;

    // Loader FSM with registered handshake outputs; cfg_start in LOAD restarts from scratch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            count_r  <= '0;
            shadow_r <= '0;
            ready_r  <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (cfg_start) begin
                        state_r <= LOAD;
                        count_r <= '0;
                        ready_r <= 1'b1;
                    end else begin
                        ready_r <= 1'b0;
                    end
                end
                LOAD: begin
                    if (cfg_start) begin
                        count_r  <= '0;
                        shadow_r <= '0;
                        ready_r  <= 1'b1;
                    end else if (cfg_valid) begin
                        shadow_r <= {shadow_r[TT_W-2:0], cfg_bit};
                        count_r  <= count_r + CNT_ONE;
                        if ((count_r + CNT_ONE) == CNT_FULL) begin
                            state_r <= COMMIT;
                            ready_r <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            ready_r <= 1'b1;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                COMMIT: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    count_r <= '0;
                    ready_r <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = ready_r;
    assign cfg_done  = done_r;
    assign commit    = (state_r == COMMIT);
    assign shadow    = shadow_r;

endmodule

// File: rtl/truth_table_seq.sv
// N-input truth-table gate with registered output and an in-system reloadable table;
// the shadow table swaps in at the end of the commit cycle, so that cycle still sees the old table.
module truth_table_seq
    import truth_table_pkg::*;
#(
    parameter  int              N_IN       = 3,
    localparam int              TT_W       = tt_width(N_IN),
    parameter  logic [TT_W-1:0] DEFAULT_TT = TT_W'(8'hB1)
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic [N_IN-1:0] in,
    input  logic            in_valid,
    output logic            out,
    output logic            out_valid,
    output logic            out_changed,
    input  logic            cfg_start,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_ready,
    output logic            cfg_done,
    output logic [TT_W-1:0] tt_active
);

    logic [TT_W-1:0] active_tt_r;
    logic [TT_W-1:0] shadow_s;
    logic            commit_s;
    logic [N_IN-1:0] tt_idx_s;
    logic            eval_bit_s;
    logic            out_r;
    logic            out_valid_r;
    logic            out_changed_r;

    truth_table_loader #(.TT_W(TT_W)) u_loader (
        .clk       (clk),
        .reset     (reset),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .cfg_done  (cfg_done),
        .commit    (commit_s),
        .shadow    (shadow_s)
    );

    // TT_W-1-idx is the bitwise complement of idx, which keeps the select index N_IN bits wide
    always_comb begin
        if (WOLFRAM_MSB_FIRST) begin
            tt_idx_s = ~in;
        end else begin
            tt_idx_s = in;
        end
        eval_bit_s = active_tt_r[tt_idx_s];
    end

    // Output registers and active table; evaluation reads the table before any commit lands
    always_ff @(posedge clk) begin
        if (reset) begin
            active_tt_r   <= DEFAULT_TT;
            out_r         <= 1'b0;
            out_valid_r   <= 1'b0;
            out_changed_r <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                out_r         <= eval_bit_s;
                out_changed_r <= eval_bit_s ^ out_r;
            end else begin
                out_changed_r <= 1'b0;
            end
            if (commit_s) begin
                active_tt_r <= shadow_s;
            end
        end
    end

    assign out         = out_r;
    assign out_valid   = out_valid_r;
    assign out_changed = out_changed_r;
    assign tt_active   = active_tt_r;

endmodule

// File: tb/tb_truth_table_seq.sv
// Self-checking bench for truth_table_seq: table-driven sweeps, hand-written load
// sequences and randomized traffic checked against a queue-based reference model.
module tb_truth_table_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] in = 3'd0;
    logic       in_valid = 1'b0;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_bit = 1'b0;
    logic       out, out_valid, out_changed, cfg_ready, cfg_done;
    logic [7:0] tt_active;

    logic [3:0]  in4 = 4'd0;
    logic        in_valid4 = 1'b0;
    logic        out4, out_valid4, out_changed4, cfg_ready4, cfg_done4;
    logic [15:0] tt_active4;
    logic        zero = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    truth_table_seq dut (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
        .out(out), .out_valid(out_valid), .out_changed(out_changed),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
        .cfg_ready(cfg_ready), .cfg_done(cfg_done), .tt_active(tt_active)
    );

    truth_table_seq #(.N_IN(4), .DEFAULT_TT(16'h8001)) dut4 (
        .clk(clk), .reset(reset), .in(in4), .in_valid(in_valid4),
        .out(out4), .out_valid(out_valid4), .out_changed(out_changed4),
        .cfg_start(zero), .cfg_valid(zero), .cfg_bit(zero),
        .cfg_ready(cfg_ready4), .cfg_done(cfg_done4), .tt_active(tt_active4)
    );

    // Reference model: active table, queue of collected bits, loader phase flags
    bit [7:0] m_act;
    bit       m_q[$];
    bit       m_loading, m_committing;
    bit       m_out, m_valid, m_chg;

    function automatic bit [7:0] q_to_table();
        bit [7:0] t = 8'd0;
        foreach (m_q[i]) t = {t[6:0], m_q[i]};
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit new_out;
        if (reset) begin
            m_act = 8'hB1; m_q.delete(); m_loading = 1'b0; m_committing = 1'b0;
            m_out = 1'b0; m_valid = 1'b0; m_chg = 1'b0;
            return;
        end
        if (in_valid) begin
            new_out = m_act[7 - int'(in)];
            m_chg   = (new_out != m_out);
            m_out   = new_out;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
            m_chg   = 1'b0;
        end
        if (m_committing) begin
            m_act = q_to_table();
            m_committing = 1'b0;
        end else if (!m_loading) begin
            if (cfg_start) begin
                m_loading = 1'b1;
                m_q.delete();
            end
        end else if (cfg_start) begin
            m_q.delete();
        end else if (cfg_valid) begin
            m_q.push_back(cfg_bit);
            if (m_q.size() == 8) begin
                m_loading = 1'b0;
                m_committing = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        chk("out", out, m_out);
        chk("out_valid", out_valid, m_valid);
        chk("out_changed", out_changed, m_chg);
        chk("cfg_ready", cfg_ready, m_loading);
        chk("cfg_done", cfg_done, m_committing);
        chk("tt_active", tt_active, m_act);
    endtask

    task automatic step(input logic s, input logic v, input logic b, input logic iv, input logic [2:0] x);
        cfg_start = s; cfg_valid = v; cfg_bit = b; in_valid = iv; in = x;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [2:0] in;
        logic       exp_out;
        logic       exp_chg;
    } vec_t;

    vec_t sweep_b1[8];
    vec_t sweep_96[8];
    int   done_cnt;
    bit   seen_done;
    logic [7:0] pat;

    initial begin
        sweep_b1[0] = '{3'd0, 1'b1, 1'b1}; sweep_b1[1] = '{3'd1, 1'b0, 1'b1};
        sweep_b1[2] = '{3'd2, 1'b1, 1'b1}; sweep_b1[3] = '{3'd3, 1'b1, 1'b0};
        sweep_b1[4] = '{3'd4, 1'b0, 1'b1}; sweep_b1[5] = '{3'd5, 1'b0, 1'b0};
        sweep_b1[6] = '{3'd6, 1'b0, 1'b0}; sweep_b1[7] = '{3'd7, 1'b1, 1'b1};
        sweep_96[0] = '{3'd0, 1'b1, 1'b0}; sweep_96[1] = '{3'd1, 1'b0, 1'b1};
        sweep_96[2] = '{3'd2, 1'b0, 1'b0}; sweep_96[3] = '{3'd3, 1'b1, 1'b1};
        sweep_96[4] = '{3'd4, 1'b0, 1'b1}; sweep_96[5] = '{3'd5, 1'b1, 1'b1};
        sweep_96[6] = '{3'd6, 1'b1, 1'b0}; sweep_96[7] = '{3'd7, 1'b0, 1'b1};

        // Reset state
        do_reset();
        chk("reset_out", out, 1'b0);
        chk("reset_tt", tt_active, 8'hB1);
        chk("reset_ready", cfg_ready, 1'b0);

        // Default table sweep
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, sweep_b1[i].in);
            chk("sweep_b1_out", out, sweep_b1[i].exp_out);
            chk("sweep_b1_chg", out_changed, sweep_b1[i].exp_chg);
        end

        // Back-to-back load of 0x96
        pat = 8'h96;
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("load_ready", cfg_ready, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            step(1'b0, 1'b1, pat[i], 1'b0, 3'd0);
            chk("load96_done", cfg_done, (i == 0) ? 1'b1 : 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("load96_tt", tt_active, 8'h96);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b1, sweep_96[i].in);
            chk("sweep_96_out", out, sweep_96[i].exp_out);
            chk("sweep_96_chg", out_changed, sweep_96[i].exp_chg);
        end

        // Gapped load of 0x00 while in=3 is evaluated every cycle
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd3);
        seen_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b1, 3'd3);
            chk("gap_out_old", out, 1'b1);
            if (i < 7) begin
                step(1'b0, 1'b0, 1'b0, 1'b1, 3'd3);
                chk("gap_out_old", out, 1'b1);
                step(1'b0, 1'b0, 1'b0, 1'b1, 3'd3);
                chk("gap_out_old", out, 1'b1);
            end
        end
        chk("gap_done", cfg_done, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd3);
        chk("gap_collision_out", out, 1'b1);
        chk("gap_tt", tt_active, 8'h00);
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd3);
        chk("gap_new_out", out, 1'b0);

        // Restart after 5 bits, then 0xFF
        done_cnt = 0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, i[0], 1'b0, 3'd0);
            if (cfg_done) done_cnt++;
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
            if (cfg_done) done_cnt++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
            if (cfg_done) done_cnt++;
        end
        chk("restart_done_count", done_cnt, 1);
        chk("restart_tt", tt_active, 8'hFF);

        // Reset in the middle of a load
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd5);
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        do_reset();
        chk("midreset_tt", tt_active, 8'hB1);
        chk("midreset_ready", cfg_ready, 1'b0);
        chk("midreset_out", out, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
            if (cfg_done) done_cnt++;
        end
        chk("midreset_no_done", done_cnt, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
                 1'($urandom), 1'($urandom), 3'($urandom));
        end

        // Four-input instance with the 0x8001 default table
        for (int i = 0; i < 16; i++) begin
            in4 = 4'(i);
            in_valid4 = 1'b1;
            step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
            chk("n4_out", out4, (i == 0 || i == 15) ? 1'b1 : 1'b0);
            chk("n4_valid", out_valid4, 1'b1);
        end
        chk("n4_tt", tt_active4, 16'h8001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
